// File: rtl/proc_multiciclo.sv
// proc_multiciclo: multicycle 16-bit-instruction core (FETCH/DECODE/EXEC/WB).
// Define PROC_SINGLE_STEP_EN to pause in STEP_WAIT after each retired instruction.
module proc_multiciclo #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_q,
   input  logic              step,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [PC_W-1:0]   pc,
   output logic              instr_done,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_STEP,
      S_HALT
   } state_t;

   state_t            state;
   logic [15:0]       ir;
   logic [DATA_W-1:0] rf [16];
   logic [DATA_W-1:0] a, b, alu_out, alu_res;
   logic              eq;
   logic [PC_W-1:0]   pc_next;
   logic [3:0]        op, rd, rt;
   logic [3:0]        q_op, q_rd, q_rs, q_rt;
   logic              q_beq, wb_en;

`ifndef PROC_SINGLE_STEP_EN
   logic unused_step;
   assign unused_step = step;
`endif

   assign op = ir[15:12];
   assign rd = ir[11:8];
   assign rt = ir[3:0];

   // operands come straight from imem_q: IR is only loaded at the end of DECODE
   assign q_op  = imem_q[15:12];
   assign q_rd  = imem_q[11:8];
   assign q_rs  = imem_q[7:4];
   assign q_rt  = imem_q[3:0];
   assign q_beq = (q_op == 4'hA);

   assign imem_addr = pc;
   assign dbg_data  = (dbg_sel == 4'd0) ? '0 : rf[dbg_sel];
   assign wb_en     = (op <= 4'd9) && (rd != 4'd0);

   always_comb begin
      alu_res = '0;
      case (op)
         4'h0:    alu_res = a + b;
         4'h1:    alu_res = a - b;
         4'h2:    alu_res = a & b;
         4'h3:    alu_res = a | b;
         4'h4:    alu_res = a ^ b;
         4'h5:    alu_res = DATA_W'($signed(a) < $signed(b));
         4'h6:    alu_res = b + DATA_W'(ir[7:4]);
         4'h7:    alu_res = b << ir[7:4];
         4'h8:    alu_res = b >> ir[7:4];
         4'h9:    alu_res = DATA_W'(ir[7:0]);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      pc_next = pc + PC_W'(1);
      case (op)
         4'hA:    if (eq) pc_next = pc + PC_W'(1) + PC_W'($signed(rt));
         4'hB:    pc_next = ir[PC_W-1:0];
         4'hF:    pc_next = pc;
         default: pc_next = pc + PC_W'(1);
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FETCH;
         pc         <= '0;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         alu_out    <= '0;
         eq         <= 1'b0;
         instr_done <= 1'b0;
         halted     <= 1'b0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else begin
         instr_done <= 1'b0;
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               ir    <= imem_q;
               a     <= q_beq ? rf[q_rd] : rf[q_rs];
               b     <= q_beq ? rf[q_rs] : rf[q_rt];
               state <= S_EXEC;
            end
            S_EXEC: begin
               alu_out    <= alu_res;
               eq         <= (a == b);
               instr_done <= 1'b1;
               state      <= S_WB;
            end
            S_WB: begin
               if (wb_en) rf[rd] <= alu_out;
               pc <= pc_next;
               if (op == 4'hF) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end
`ifdef PROC_SINGLE_STEP_EN
               else state <= S_STEP;
`else
               else state <= S_FETCH;
`endif
            end
`ifdef PROC_SINGLE_STEP_EN
            S_STEP: if (step) state <= S_FETCH;
`endif
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_multiciclo.sv
// Directed bench for proc_multiciclo: two cores (DATA_W 16 and 8)
// run the same ROM image; hand-computed register and PC values.
module tb_proc_multiciclo;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        step;
   logic [3:0]  dbg_sel;
   logic [15:0] rom [256];
   logic [7:0]  addr16, addr8, pc16, pc8;
   logic [15:0] q16, q8, dbg16;
   logic [7:0]  dbg8;
   logic        done16, done8, halt16, halt8;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      q16 <= rom[addr16];
      q8  <= rom[addr8];
   end

   proc_multiciclo #(.DATA_W(16), .PC_W(8)) u16 (
      .CLOCK_50(clk), .reset_n(reset_n), .imem_addr(addr16), .imem_q(q16),
      .step(step), .dbg_sel(dbg_sel), .dbg_data(dbg16), .pc(pc16),
      .instr_done(done16), .halted(halt16)
   );

   proc_multiciclo #(.DATA_W(8), .PC_W(8)) u8 (
      .CLOCK_50(clk), .reset_n(reset_n), .imem_addr(addr8), .imem_q(q8),
      .step(step), .dbg_sel(dbg_sel), .dbg_data(dbg8), .pc(pc8),
      .instr_done(done8), .halted(halt8)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic rd(input logic [3:0] idx, output logic [15:0] v16,
                     output logic [7:0] v8);
      dbg_sel = idx;
      #1;
      v16 = dbg16;
      v8  = dbg8;
   endtask

   // returns at the FETCH cycle following the next retired instruction
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done16 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check({tag, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   task automatic run_halt(output int ndone, output int last_cyc);
      int cyc;
      cyc      = 0;
      ndone    = 0;
      last_cyc = 0;
      while (!halt16 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (done16) begin
            ndone++;
            last_cyc = cyc + 1;
         end
      end
      if (cyc >= 300) check("halt_timeout", 0, 1);
   endtask

   initial begin
      logic [15:0] v16;
      logic [7:0]  v8;
      int          nd, lc;

      reset_n = 1'b0;
      step    = 1'b0;
      dbg_sel = 4'd0;
      clear_rom();
      rom[0] = 16'h9105;
      rom[1] = 16'h9203;
      rom[2] = 16'h0312;
      rom[3] = 16'hF000;

`ifdef PROC_SINGLE_STEP_EN
      do_reset();
      wait_done("ss_first");
      check("ss_pc1", pc16, 1);
      nd = 0;
      repeat (50) begin
         @(negedge clk);
         if (done16) nd++;
      end
      check("ss_hold_done", nd, 0);
      check("ss_hold_pc", pc16, 1);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done16) nd++;
      end
      check("ss_one_step", nd, 1);
      check("ss_pc2", pc16, 2);
`endif

      // step held high: ignored in free-run, keeps single-step builds moving
      step = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", pc16, 0);
      check("rst_addr", addr16, 0);
      check("rst_done", done16, 0);
      check("rst_halt", halt16, 0);
      rd(4'd1, v16, v8);
      check("rst_r1", v16, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_halt(nd, lc);
      check("t1_done_cnt", nd, 4);
`ifndef PROC_SINGLE_STEP_EN
      check("t1_last_wb_cycle", lc, 16);
`endif
      check("t1_halted", halt16, 1);
      rd(4'd3, v16, v8);
      check("t1_r3", v16, 16'd8);
      repeat (5) @(negedge clk);
      check("t1_pc_hold", pc16, 3);
      check("t1_halt_hold", halt16, 1);

      clear_rom();
      rom[0] = 16'h9105;
      rom[1] = 16'h9203;
      rom[2] = 16'h1421;
      rom[3] = 16'h5541;
      rom[4] = 16'h9009;
      rom[5] = 16'h76F1;
      rom[6] = 16'h6742;
      rom[7] = 16'h8844;
      rom[8] = 16'h4912;
      rom[9] = 16'hF000;
      do_reset();
      run_halt(nd, lc);
      check("t2_pc", pc16, 9);
      rd(4'd4, v16, v8);
      check("sub16", v16, 16'hFFFE);
      check("sub8", v8, 8'hFE);
      rd(4'd5, v16, v8);
      check("slt16", v16, 1);
      check("slt8", v8, 1);
      rd(4'd0, v16, v8);
      check("r0_16", v16, 0);
      check("r0_8", v8, 0);
      rd(4'd6, v16, v8);
      check("shl16", v16, 16'h8000);
      check("shl8_sat", v8, 0);
      rd(4'd7, v16, v8);
      check("addi16", v16, 7);
      rd(4'd8, v16, v8);
      check("shr16", v16, 16'h0FFF);
      check("shr8", v8, 8'h0F);
      rd(4'd9, v16, v8);
      check("xor16", v16, 6);

      clear_rom();
      rom[0] = 16'h9105;
      rom[1] = 16'h9203;
      rom[2] = 16'hA123;
      rom[3] = 16'hC000;
      rom[4] = 16'hA11E;
      do_reset();
      wait_done("b0");
      wait_done("b1");
      check("li_pc", pc16, 2);
      wait_done("b2");
      check("beq_ne_pc", pc16, 3);
      wait_done("b3");
      check("nop_pc", pc16, 4);
      wait_done("b4");
      check("beq_back_pc", pc16, 3);
      check("beq_back_pc8", pc8, 3);

      clear_rom();
      rom[0]   = 16'hB0FF;
      rom[255] = 16'h9107;
      do_reset();
      wait_done("j0");
      check("jmp_pc", pc16, 8'hFF);
      wait_done("j1");
      check("wrap_pc", pc16, 0);
      rd(4'd1, v16, v8);
      check("wrap_r1", v16, 7);

      clear_rom();
      rom[0] = 16'h9105;
      rom[1] = 16'h9203;
      rom[2] = 16'h0712;
      rom[3] = 16'hF000;
      do_reset();
      repeat (10) @(negedge clk);
      check("mid_pc", pc16, 2);
      reset_n = 1'b0;
      #1;
      rd(4'd7, v16, v8);
      check("abort_r7", v16, 0);
      check("abort_pc", pc16, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_halt(nd, lc);
      check("restart_cnt", nd, 4);
      rd(4'd7, v16, v8);
      check("restart_r7", v16, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
